memory_request_arbiter: RTL
===========================

// Module: memory_request_arbiter
// PURPOSE
//  Shares the single RAM port between the instruction request (iREN) and the data request (dREN/dWEN).
//  Sits between the request unit / control path and RAM. Generates ihit/dhit and returns load data.
//  Data requests have priority, with a fairness limit so instruction fetch cannot starve.
//  Halt blocks new fetches.
// PARAMETERS
//  ADDR_W      32  width of the byte address
//  WORD_W      32  width of the data word
//  MAX_DSTREAK 4   consecutive data grants allowed while iREN pending before one fetch is forced
//  TIMEOUT     16  cycles an access may wait for ram_ready (used only with ARB_TIMEOUT_EN)
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       synchronous reset, active low
//  iREN       in   1       instruction read request; held until ihit
//  iaddr      in   ADDR_W  instruction address
//  dREN       in   1       data read request; held until dhit
//  dWEN       in   1       data write request; held until dhit
//  daddr      in   ADDR_W  data address
//  dstore     in   WORD_W  data to write
//  halt       in   1       CPU halted; suppresses new instruction grants
//  ram_ready  in   1       RAM completes the current access this cycle
//  ramload    in   WORD_W  RAM read data (valid when ram_ready)
//  ramREN     out  1       RAM read strobe
//  ramWEN     out  1       RAM write strobe
//  ramaddr    out  ADDR_W  RAM address
//  ramstore   out  WORD_W  RAM write data
//  ihit       out  1       one-cycle pulse; instruction access done
//  dhit       out  1       one-cycle pulse; data access done
//  iload      out  WORD_W  fetched instruction, registered, valid from the ihit cycle until next ihit
//  dload      out  WORD_W  loaded data, registered, valid from the dhit cycle until next dhit
//  timeout    out  1       sticky watchdog flag (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Clock and reset
//   - One clock. Reset is synchronous and active-low: nRST low at a rising CLK edge resets the block.
//   - Reset: state=IDLE; every output = 0 (ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, timeout).
//   - Reset: dstreak=0, wdog=0. Reset mid-access abandons the access; no hit is issued.
//  FSM states: IDLE, IACC, DACC
//   - IDLE -> DACC when (dREN|dWEN) && !(iREN && !halt && dstreak==MAX_DSTREAK).
//   - IDLE -> IACC when iREN && !halt and the DACC condition is false.
//   - On the grant edge, latch addr/store/write-flag.
//   - dREN and dWEN both high: treated as a write.
//  Access states (IACC, DACC)
//   - Drive ramaddr / ramstore and ramREN or ramWEN from the latched values.
//   - The access holds until ram_ready. In that cycle, pulse ihit or dhit combinationally.
//   - Capture ramload into iload/dload on that edge (DACC read only); then return to IDLE.
//   - Outside access states, ram strobes = 0.
//  Latency
//   - Request seen in IDLE at cycle N: strobe at N+1; hit at N+1 at the earliest (ram_ready=1).
//   - Back-to-back accesses are separated by one IDLE cycle.
//  dstreak
//   - +1 on each data grant while iREN && !halt; saturates at MAX_DSTREAK.
//   - Cleared on an instruction grant, or whenever iREN is low or halt is high.
//  Halt
//   - halt high during IACC: the in-flight fetch completes normally.
//   - halt high in IDLE: no IACC entry; data is still served.
//  Requester rules
//   - Requests must stay asserted with stable addr/data until their hit; the block does not check this.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined
//   - wdog counts cycles in IACC/DACC without ram_ready.
//   - When wdog reaches TIMEOUT: set sticky timeout=1, force IDLE, issue no hit.
//   - timeout is cleared only by reset.
//  ARB_TIMEOUT_EN undefined
//   - No counter; timeout tied 0; an access waits on ram_ready indefinitely.
// STRUCTURE
//  - cpu_types_pkg: add arb_state_t enum {IDLE, IACC, DACC}; use the existing word_t for data.
//  - Sub-module arb_watchdog (counter + sticky flag), instantiated only under ARB_TIMEOUT_EN.
//  - FSM, dstreak and output muxing stay in this module.
// TESTING
//  1. iREN=1, iaddr=0x40, ram_ready=1 always -> ramREN at cycle 1, ihit pulse cycle 1, iload=ramload.
//  2. iREN and dREN both held, ram_ready=1 -> grants D,D,D,D,I,D... ; ihit after exactly 4 dhits.
//  3. dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ram_ready low 3 cycles -> ramWEN high 4 cycles, dhit only on cycle 4.
//  4. halt=1, iREN=1, dREN=1 -> only data grants; ihit never asserts; dstreak stays 0.
//  5. nRST low during DACC with ram_ready=0 -> next cycle IDLE, all outputs 0, no dhit after release.
//  6. ARB_TIMEOUT_EN, TIMEOUT=16, ram_ready stuck 0 -> timeout=1 at 16th access cycle, FSM IDLE, no hit.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_request_arbiter_watchdog.sv
// Access watchdog for the memory arbiter: counts stalled access cycles and
// raises a sticky timeout flag when the limit is reached.
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;

    // The limit is hit in the TIMEOUT-th stalled cycle itself, so the flag is visible then.
    assign expire_o  = active_i && !ready_i && (wdog_q == CW'(TIMEOUT - 1));
    assign timeout_o = timeout_q || expire_o;

    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q || expire_o;
        if (!active_i || ready_i || expire_o) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/memory_request_arbiter.sv
// Shares the single RAM port between instruction fetch and data accesses,
// data first with a fetch-starvation limit. Watchdog optional via ARB_TIMEOUT_EN.
module memory_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              halt,
    input  logic              ram_ready,
    input  logic [WORD_W-1:0] ramload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              timeout
);

    localparam int unsigned DS_W = $clog2(MAX_DSTREAK + 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] iload_q, dload_q;
    logic [DS_W-1:0]   dstreak_q, dstreak_d;

    logic ireq, dreq, force_i, dgrant, igrant, in_acc, done, expire;

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (CLK),
        .nrst_i    (nRST),
        .active_i  (in_acc),
        .ready_i   (ram_ready),
        .expire_o  (expire),
        .timeout_o (timeout)
    );
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign ireq    = iREN && !halt;
    assign dreq    = dREN || dWEN;
    assign force_i = ireq && (dstreak_q == DS_W'(MAX_DSTREAK));
    assign dgrant  = (state_q == IDLE) && dreq && !force_i;
    assign igrant  = (state_q == IDLE) && ireq && !dgrant;
    assign in_acc  = (state_q != IDLE);
    assign done    = in_acc && ram_ready && !expire;

    assign ihit     = (state_q == IACC) && done;
    assign dhit     = (state_q == DACC) && done;
    assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
    assign ramWEN   = (state_q == DACC) && wr_q;
    assign ramaddr  = in_acc ? addr_q : '0;
    assign ramstore = ramWEN ? store_q : '0;

    // Load data bypasses the holding register in the hit cycle so it is valid from the hit onward.
    assign iload = ihit ? ramload : iload_q;
    assign dload = (dhit && !wr_q) ? ramload : dload_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        dstreak_d = dstreak_q;

        if (dgrant) begin
            state_d = DACC;
            addr_d  = daddr;
            store_d = dstore;
            wr_d    = dWEN;
        end else if (igrant) begin
            state_d = IACC;
            addr_d  = iaddr;
            store_d = '0;
            wr_d    = 1'b0;
        end else if (done || expire) begin
            state_d = IDLE;
        end

        if (!ireq || igrant) begin
            dstreak_d = '0;
        end else if (dgrant && (dstreak_q != DS_W'(MAX_DSTREAK))) begin
            dstreak_d = dstreak_q + DS_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            store_q   <= '0;
            wr_q      <= 1'b0;
            iload_q   <= '0;
            dload_q   <= '0;
            dstreak_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            wr_q      <= wr_d;
            iload_q   <= iload;
            dload_q   <= dload;
            dstreak_q <= dstreak_d;
        end
    end

endmodule
